// File: rtl/bcd_score_display.sv
// Score/best-score display selector feeding the 7-segment decoder stage.
// Keeps the best score internally and blinks the display after a new record.
module bcd_score_display #(
  parameter int DIGITS          = 4,
  parameter int LOWER_IS_BETTER = 1,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [1:0]            state,
  input  logic [4*DIGITS-1:0]   score,
  input  logic                  score_valid,
  input  logic                  clear_hs,
  output logic [4*DIGITS-1:0]   disp,
  output logic [DIGITS-1:0]     blank,
  output logic                  new_high,
  output logic                  bad_bcd
);

  localparam int W     = 4*DIGITS;
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [W-1:0] HS_INIT = (LOWER_IS_BETTER != 0) ? {DIGITS{4'h9}} : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_OTHER = 2'd3
  } game_state_t;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Packed BCD compares correctly as plain unsigned binary.
  function automatic logic is_record(input logic [W-1:0] cand, input logic [W-1:0] ref_v);
    return (LOWER_IS_BETTER != 0) ? (cand < ref_v) : (cand > ref_v);
  endfunction

  logic [W-1:0]      r_best;
  logic [W-1:0]      r_final;
  logic [W-1:0]      r_disp;
  logic [DIGITS-1:0] r_blank;
  logic              r_new_high;
  logic              r_bad_bcd;
  logic [CNT_W-1:0]  r_blink_cnt;
  logic              r_phase;

  game_state_t       w_state;
  logic              w_blink_on;
  logic              w_cnt_wrap;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_phase_next;
  logic              w_bad_digit;
  logic              w_record;

  assign w_state     = game_state_t'(state);
  assign w_blink_on  = (w_state == ST_DONE) && r_new_high;
  assign w_cnt_wrap  = (r_blink_cnt == CNT_W'(BLINK_DIV - 1));
  assign w_bad_digit = has_bad_digit(score);
  assign w_record    = is_record(score, r_best);

  // blank follows the next phase so the first dark half lands BLINK_DIV cycles in
  always_comb begin
    w_cnt_next   = '0;
    w_phase_next = 1'b0;
    if (w_blink_on) begin
      w_cnt_next   = w_cnt_wrap ? '0 : r_blink_cnt + 1'b1;
      w_phase_next = w_cnt_wrap ? ~r_phase : r_phase;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_best      <= HS_INIT;
      r_final     <= '0;
      r_disp      <= HS_INIT;
      r_blank     <= '0;
      r_new_high  <= 1'b0;
      r_bad_bcd   <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_blink_cnt <= w_cnt_next;
      r_phase     <= w_phase_next;
      r_blank     <= {DIGITS{w_phase_next}};

      case (w_state)
        ST_IDLE: r_disp <= r_best;
        ST_DONE: r_disp <= r_final;
        default: r_disp <= score;
      endcase

      r_bad_bcd <= 1'b0;
      if (w_state == ST_IDLE) r_new_high <= 1'b0;

      // A round result overrides the idle clear of new_high in the same cycle.
      if (clear_hs) begin
        r_best     <= HS_INIT;
        r_new_high <= 1'b0;
      end else if (score_valid) begin
        if (w_bad_digit) begin
          r_bad_bcd <= 1'b1;
        end else begin
          r_final <= score;
          if (w_record) begin
            r_best     <= score;
            r_new_high <= 1'b1;
          end else begin
            r_new_high <= 1'b0;
          end
        end
      end
    end
  end

  assign disp     = r_disp;
  assign blank    = r_blank;
  assign new_high = r_new_high;
  assign bad_bcd  = r_bad_bcd;

endmodule

// File: tb/tb_bcd_score_display.sv
// Bench for bcd_score_display: a 4-digit lower-is-better instance checked
// against a reference model every cycle, and a 6-digit higher-is-better instance.
module tb_bcd_score_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_sv, a_clr;
  logic [1:0]  a_state;
  logic [15:0] a_score, a_disp;
  logic [3:0]  a_blank;
  logic        a_nh, a_bad;

  logic        b_reset, b_sv, b_clr;
  logic [1:0]  b_state;
  logic [23:0] b_score, b_disp;
  logic [5:0]  b_blank;
  logic        b_nh, b_bad;

  bcd_score_display #(.DIGITS(4), .LOWER_IS_BETTER(1), .BLINK_DIV(4)) u_dut_a (
    .Clk(clk), .Reset(a_reset), .state(a_state), .score(a_score),
    .score_valid(a_sv), .clear_hs(a_clr), .disp(a_disp), .blank(a_blank),
    .new_high(a_nh), .bad_bcd(a_bad)
  );

  bcd_score_display #(.DIGITS(6), .LOWER_IS_BETTER(0), .BLINK_DIV(4)) u_dut_b (
    .Clk(clk), .Reset(b_reset), .state(b_state), .score(b_score),
    .score_valid(b_sv), .clear_hs(b_clr), .disp(b_disp), .blank(b_blank),
    .new_high(b_nh), .bad_bcd(b_bad)
  );

  typedef struct packed {
    logic [31:0] disp;
    logic [7:0]  blank;
    logic        nh;
    logic        bad;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the 4-digit lower-is-better instance.
  logic [15:0] m_best, m_final, m_disp;
  logic [3:0]  m_blank;
  logic        m_nh, m_bad;
  int          m_on;

  function automatic logic bcd_ok16(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_a_step();
    logic [15:0] n_disp;
    logic        n_nh;
    if (a_reset) begin
      m_best = 16'h9999; m_final = 16'h0; m_disp = 16'h9999;
      m_blank = 4'h0; m_nh = 1'b0; m_bad = 1'b0; m_on = 0;
    end else begin
      case (a_state)
        2'd0:    n_disp = m_best;
        2'd2:    n_disp = m_final;
        default: n_disp = a_score;
      endcase
      // m_on counts consecutive edges with the blink condition held
      if (a_state == 2'd2 && m_nh) begin
        m_on++;
        m_blank = (((m_on / 4) % 2) == 1) ? 4'hF : 4'h0;
      end else begin
        m_on = 0;
        m_blank = 4'h0;
      end
      n_nh  = (a_state == 2'd0) ? 1'b0 : m_nh;
      m_bad = 1'b0;
      if (a_clr) begin
        m_best = 16'h9999;
        n_nh   = 1'b0;
      end else if (a_sv) begin
        if (!bcd_ok16(a_score)) begin
          m_bad = 1'b1;
        end else begin
          m_final = a_score;
          if (a_score < m_best) begin
            m_best = a_score;
            n_nh   = 1'b1;
          end else begin
            n_nh = 1'b0;
          end
        end
      end
      m_nh   = n_nh;
      m_disp = n_disp;
    end
  endtask

  task automatic cyc_a(input logic rst, input logic [1:0] st, input logic [15:0] sc,
                       input logic sv, input logic clr);
    exp_t e;
    a_reset = rst; a_state = st; a_score = sc; a_sv = sv; a_clr = clr;
    model_a_step();
    e.disp  = {16'h0, m_disp};
    e.blank = {4'h0, m_blank};
    e.nh    = m_nh;
    e.bad   = m_bad;
    qa.push_back(e);
    @(posedge clk);
    #1;
    e = qa.pop_front();
    check("a_disp",     {16'h0, a_disp},     e.disp);
    check("a_blank",    {28'h0, a_blank},    {24'h0, e.blank});
    check("a_new_high", {31'h0, a_nh},       {31'h0, e.nh});
    check("a_bad_bcd",  {31'h0, a_bad},      {31'h0, e.bad});
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic rst, input logic [1:0] st, input logic [23:0] sc,
                       input logic sv, input logic [23:0] x_disp, input logic x_nh,
                       input logic x_bad);
    exp_t e;
    b_reset = rst; b_state = st; b_score = sc; b_sv = sv; b_clr = 1'b0;
    e.disp = {8'h0, x_disp}; e.blank = 8'h0; e.nh = x_nh; e.bad = x_bad;
    qb.push_back(e);
    @(posedge clk);
    #1;
    e = qb.pop_front();
    check("b_disp",     {8'h0, b_disp},  e.disp);
    check("b_blank",    {26'h0, b_blank}, {24'h0, e.blank});
    check("b_new_high", {31'h0, b_nh},   {31'h0, e.nh});
    check("b_bad_bcd",  {31'h0, b_bad},  {31'h0, e.bad});
    @(negedge clk);
  endtask

  task automatic idle_a(input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) cyc_a(1'b0, st, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] rs;
    a_reset = 1'b1; a_state = 2'd0; a_score = '0; a_sv = 1'b0; a_clr = 1'b0;
    b_reset = 1'b1; b_state = 2'd0; b_score = '0; b_sv = 1'b0; b_clr = 1'b0;
    @(negedge clk);

    // Reset and idle display of the initial best
    cyc_a(1'b1, 2'd0, 16'h0000, 1'b0, 1'b0);
    cyc_a(1'b1, 2'd0, 16'h0000, 1'b0, 1'b0);
    idle_a(2, 2'd0);
    check("plan_reset_disp", {16'h0, a_disp}, 32'h0000_9999);

    // New record, then blink in DONE, then idle shows the record
    cyc_a(1'b0, 2'd1, 16'h0312, 1'b0, 1'b0);
    cyc_a(1'b0, 2'd1, 16'h0312, 1'b1, 1'b0);
    check("plan_record_nh", {31'h0, a_nh}, 32'h1);
    for (int i = 0; i < 13; i++) cyc_a(1'b0, 2'd2, 16'h0000, 1'b0, 1'b0);
    idle_a(2, 2'd0);
    check("plan_idle_best", {16'h0, a_disp}, 32'h0000_0312);

    // Equal and worse scores are not records
    cyc_a(1'b0, 2'd1, 16'h0312, 1'b1, 1'b0);
    idle_a(6, 2'd2);
    cyc_a(1'b0, 2'd1, 16'h0500, 1'b1, 1'b0);
    idle_a(6, 2'd2);
    idle_a(2, 2'd0);
    check("plan_worse_best", {16'h0, a_disp}, 32'h0000_0312);

    // Invalid BCD digit
    cyc_a(1'b0, 2'd1, 16'h02A1, 1'b1, 1'b0);
    check("plan_bad_pulse", {31'h0, a_bad}, 32'h1);
    idle_a(3, 2'd2);
    idle_a(2, 2'd0);

    // clear_hs together with score_valid
    cyc_a(1'b0, 2'd1, 16'h0100, 1'b1, 1'b1);
    idle_a(2, 2'd0);
    idle_a(2, 2'd2);
    check("plan_clear_final", {16'h0, a_disp}, 32'h0000_0500);

    // Reset in the middle of blinking
    cyc_a(1'b0, 2'd1, 16'h0042, 1'b1, 1'b0);
    idle_a(6, 2'd2);
    cyc_a(1'b1, 2'd2, 16'h0000, 1'b0, 1'b0);
    idle_a(2, 2'd0);

    // clear_hs alone
    cyc_a(1'b0, 2'd3, 16'h0042, 1'b1, 1'b0);
    cyc_a(1'b0, 2'd1, 16'h0000, 1'b0, 1'b1);
    idle_a(2, 2'd0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 4; d++)
        rs[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
      cyc_a(($urandom_range(0, 60) == 0), 2'($urandom_range(0, 3)), rs,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 25) == 0));
    end

    // Six-digit higher-is-better instance
    a_reset = 1'b1;
    cyc_b(1'b1, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd1, 24'h000123, 1'b1, 24'h000123, 1'b1, 1'b0);
    cyc_b(1'b0, 2'd0, 24'h000000, 1'b0, 24'h000123, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd1, 24'h000099, 1'b1, 24'h000099, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd0, 24'h000000, 1'b0, 24'h000123, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd1, 24'h000123, 1'b1, 24'h000123, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd1, 24'h0000A0, 1'b1, 24'h0000A0, 1'b0, 1'b1);
    cyc_b(1'b0, 2'd1, 24'h999999, 1'b1, 24'h999999, 1'b1, 1'b0);
    cyc_b(1'b0, 2'd2, 24'h000000, 1'b0, 24'h999999, 1'b1, 1'b0);
    cyc_b(1'b0, 2'd0, 24'h000000, 1'b0, 24'h999999, 1'b0, 1'b0);
    cyc_b(1'b0, 2'd0, 24'h000000, 1'b0, 24'h999999, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_score_display.md
Name: bcd_score_display

Overview:
- Parametrised successor to the 4-digit score/high-score display selector; drives the 7-segment decoder stage.
- Holds the best-score register internally; no external high-score bus.
- Compares each finished round against the stored best, with selectable lower-is-better or higher-is-better.
- Selects live, final or best score per game state; blinks the display when a new record is set.

Parameters:
- DIGITS, 4: number of BCD digits; digit 0 is the least significant.
- LOWER_IS_BETTER, 1: 1 means the smaller score is the record (reaction timer); 0 means the larger score is the record.
- BLINK_DIV, 25000000: Clk cycles per blink half-period; must be at least 2.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- state  in  2  game state: 0=IDLE, 1=RUN, 2=DONE, 3=other.
- score  in  4*DIGITS  live BCD score; digit i is bits [4i+3:4i].
- score_valid  in  1  one-cycle pulse: score holds a finished round's final value.
- clear_hs  in  1  one-cycle pulse: reset the best score to its initial value.
- disp  out  4*DIGITS  registered BCD digits to the decoder.
- blank  out  DIGITS  registered per-digit blank; 1 means the digit is dark.
- new_high  out  1  registered: the last accepted round set a record.
- bad_bcd  out  1  registered one-cycle pulse: a score_valid carried a digit above 9.

Behaviour:
- Reset (synchronous, active-high):
  - best = HS_INIT; HS_INIT is all digits 9 if LOWER_IS_BETTER, else all 0.
  - disp = HS_INIT, blank = 0, new_high = 0, bad_bcd = 0, final = 0, blink counter = 0, blink phase = 0.
  - Reset overrides every other input in the same cycle.
- Ordering: for valid BCD, unsigned comparison of the packed vectors equals numeric order, so no digit-serial compare is needed.
- Update at a score_valid edge, checked in this priority order:
  1. clear_hs=1: best <= HS_INIT, new_high <= 0. score_valid is ignored entirely: no final capture, no bad_bcd.
  2. Any score digit > 9: best and final unchanged, bad_bcd <= 1 for one cycle, new_high unchanged.
  3. Otherwise final <= score.
  4. Record test, strict: score < best (LOWER_IS_BETTER=1) or score > best (=0).
     - Record: best <= score, new_high <= 1.
     - No record: new_high <= 0.
     - A score equal to best is not a record.
- clear_hs alone, without score_valid: best <= HS_INIT, new_high <= 0.
- Record-test latency:
  - The test uses best as registered before this edge.
  - new_high and best change one cycle after the score_valid edge.
  - disp reflects the new best one further cycle later, so display latency is 2 cycles.
- new_high clearing:
  - Cleared on Reset and on clear_hs.
  - Cleared on the first edge where state == IDLE.
  - Otherwise held.
- Display select, registered, 1-cycle latency from state/score/best:
  - IDLE: disp <= best.
  - RUN: disp <= score.
  - DONE: disp <= final.
  - 3: disp <= score.
- Blink:
  - Counter runs only while state == DONE and new_high == 1.
  - At BLINK_DIV-1 the counter wraps to 0 and the blink phase toggles.
  - blank <= all 1 when phase == 1 in that condition, else all 0.
  - Leaving that condition: counter <= 0, phase <= 0, blank <= 0 on the next edge.
  - The first dark half starts exactly BLINK_DIV cycles after the condition became true.
- No leading-zero suppression; blank is driven by blink only.
- score_valid may arrive in any state; the update is state-independent.

Test Plan:
1. Reset, then state=IDLE -> disp=16'h9999, blank=0, new_high=0 (LOWER_IS_BETTER=1, DIGITS=4).
2. score=16'h0312, pulse score_valid, state=DONE -> new_high=1 one cycle later; disp=16'h0312; with BLINK_DIV=4, blank toggles 0000/1111 every 4 cycles; state=IDLE -> disp=16'h0312, blank=0, new_high=0.
3. Equal and worse scores: with best=0312, score_valid with 16'h0312 then 16'h0500 -> best stays 0312, new_high=0, no blinking in DONE.
4. Invalid BCD: score_valid with score=16'h02A1 -> bad_bcd pulses for one cycle; best and final are unchanged.
5. Simultaneous events: clear_hs and score_valid (score=16'h0100) on the same edge -> best=9999, new_high=0, final unchanged; Reset asserted mid-blink -> blank=0 and disp=9999 on the next edge.
6. LOWER_IS_BETTER=0, DIGITS=6: Reset gives best=0; score_valid with 24'h000123 -> record, best=000123; then 24'h000099 -> no record.
